uart_rx_fifo: RTL

Byte buffer directly downstream of the UART receiver. It takes the receiver's byte-valid status and data, which come from the 16x baud clock domain. It synchronises the status into the system clock domain and stores each received byte once in a circular FIFO. The control logic drains it through a first-word-fall-through read port. Bytes that arrive while the FIFO is full are dropped and latched into a sticky overflow flag.

---
 rtl/uart_rx_fifo.sv | 105 ++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer behind the UART receiver.
// It synchronises the receiver's byte-valid level into clk, turns each rising edge into
// one write, and exposes a first-word-fall-through read port. A byte that arrives while
// the FIFO is full is dropped and recorded in a sticky overflow flag.
module uart_rx_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_status,
    input  logic [7:0]        rx_data,
    input  logic              rd_en,
    output logic [7:0]        rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              clr_ovf
);

    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned DATA_W = 8;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              s1;
    logic              s2;
    logic              s3;
    logic              wr_req;
    logic              rd_valid;
    logic              wr_accept;
    logic              drop;

    // Two-flop synchroniser plus edge flop for the asynchronous byte-valid level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= rx_status;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Write/read qualification; a read frees the slot a same-cycle write needs when full
    always_comb begin
        wr_req    = s2 & ~s3;
        rd_valid  = rd_en & ~empty;
        wr_accept = wr_req & (~full | rd_valid);
        drop      = wr_req & full & ~rd_valid;
    end

    // Status flags decoded from the registered occupancy
    always_comb begin
        empty = (count == '0);
        full  = (count == CNT_W'(DEPTH));
    end

    // Fall-through read straight from the array
    assign rd_data = mem[rd_ptr];

    // Storage array; data is taken from rx_data, which is long stable by the write edge
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at ADDR_W bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_valid) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({wr_accept, rd_valid})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps the flag set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule
